// File: rtl/relu1_seq_if.sv
// Handshake and buffer bus between the conv1 ReLU sequencer and its environment:
// conv1 buffer read port, ReLU stage enable/done handshake, pool1 buffer write
// port, and the sequencer's control/status lines.
interface relu1_seq_if #(
    parameter int DATA_W = 22,
    parameter int ADDR_W = 10
);
    logic                     start;
    logic        [ADDR_W-1:0] rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     relu_enable;
    logic signed [DATA_W-1:0] relu_in;
    logic signed [DATA_W-1:0] relu_out;
    logic                     relu_done;
    logic                     wr_en;
    logic        [ADDR_W-1:0] wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     busy;
    logic                     done;
    logic        [1:0]        err;

    // The sequencer side drives addresses, the stage enable and the write port.
    modport master (
        input  start, rd_data, relu_out, relu_done,
        output rd_addr, relu_enable, relu_in, wr_en, wr_addr, wr_data, busy, done, err
    );

    // The environment side: buffers, ReLU stage and the requester.
    modport slave (
        output start, rd_data, relu_out, relu_done,
        input  rd_addr, relu_enable, relu_in, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/relu1_seq.sv
// Layer sequencer for the conv1 ReLU stage. Streams every conv1 result through
// the stage one element at a time and writes the rectified value into the
// pool1 buffer, then pulses done. Flags a stalled stage (err[0]) and any
// negative value returned by the stage (err[1]).
module relu1_seq #(
    parameter int DATA_W  = 22,
    parameter int N_ELEM  = 576,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input logic        clk,
    input logic        rst_n,
    relu1_seq_if.master bus
);

    localparam int                TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_EN,
        S_WR,
        S_REL,
        S_FIN
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic        [ADDR_W-1:0] r_idx;
    logic        [TMR_W-1:0]  r_timer;
    logic signed [DATA_W-1:0] r_reluIn;
    logic        [ADDR_W-1:0] r_wrAddr;
    logic signed [DATA_W-1:0] r_wrData;
    logic        [1:0]        r_err;

    // State register; reset aborts any element in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; REL holds until the stage drops done so every enable edge yields one capture.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_RD;
            S_RD:   w_next = S_LAT;
            S_LAT:  w_next = S_EN;
            S_EN: begin
                if (bus.relu_done) begin
                    w_next = S_WR;
                end else if (r_timer == TMR_LAST) begin
                    w_next = S_FIN;
                end
            end
            S_WR:   w_next = S_REL;
            S_REL: begin
                if (!bus.relu_done) begin
                    w_next = (r_idx == LAST_IDX) ? S_FIN : S_RD;
                end
            end
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall timer counts EN cycles and clears everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == S_EN) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    // Element index, stage operand, captured result and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_reluIn <= '0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_err    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_idx <= '0;
                        r_err <= '0;
                    end
                end
                S_LAT: r_reluIn <= bus.rd_data;
                S_EN: begin
                    if (bus.relu_done) begin
                        r_wrData <= bus.relu_out;
                        r_wrAddr <= r_idx;
                        if (bus.relu_out[DATA_W-1]) begin
                            r_err[1] <= 1'b1;
                        end
                    end else if (r_timer == TMR_LAST) begin
                        r_err[0] <= 1'b1;
                    end
                end
                S_REL: begin
                    if (!bus.relu_done && (r_idx != LAST_IDX)) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_addr     = r_idx;
    assign bus.relu_in     = r_reluIn;
    assign bus.relu_enable = (r_state == S_EN);
    assign bus.wr_en       = (r_state == S_WR);
    assign bus.wr_addr     = r_wrAddr;
    assign bus.wr_data     = r_wrData;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_FIN);
    assign bus.err         = r_err;

endmodule

// File: tb/tb_relu1_seq.sv
// Bench for relu1_seq: a 4-element instance for timing, stall, fault, reset
// and back-to-back scenarios, and a 576-element instance for a full random map.
// Both share one clock and reset; buffers and the ReLU stage are modelled here.
module tb_relu1_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    relu1_seq_if #(.DATA_W(22), .ADDR_W(10)) ifS ();
    relu1_seq_if #(.DATA_W(22), .ADDR_W(10)) ifB ();

    relu1_seq #(.DATA_W(22), .N_ELEM(4), .ADDR_W(10), .TIMEOUT(15)) dutS (
        .clk(clk), .rst_n(rst_n), .bus(ifS)
    );
    relu1_seq #(.DATA_W(22), .N_ELEM(576), .ADDR_W(10), .TIMEOUT(15)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB)
    );

    typedef struct packed {
        logic        [9:0]  addr;
        logic signed [21:0] data;
    } wr_t;

    wr_t expQ[$];
    int compared = 0;
    int mismatched = 0;

    logic signed [21:0] memS [4];
    logic signed [21:0] memB [576];
    logic               stallOn = 1'b0;
    logic [9:0]         stallAddr = '0;
    logic               faultOn = 1'b0;
    logic [9:0]         faultAddr = '0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Conv1 buffers: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        ifS.rd_data <= memS[ifS.rd_addr[1:0]];
        ifB.rd_data <= (ifB.rd_addr < 10'd576) ? memB[ifB.rd_addr] : '0;
    end

    // ReLU stages registering done one cycle after enable, with optional stall/fault on the small one.
    always @(posedge clk) begin
        ifS.relu_done <= ifS.relu_enable && !(stallOn && ifS.rd_addr == stallAddr);
        ifS.relu_out  <= (faultOn && ifS.rd_addr == faultAddr) ? -22'sd1
                       : (ifS.relu_in[21] ? 22'sd0 : ifS.relu_in);
        ifB.relu_done <= ifB.relu_enable;
        ifB.relu_out  <= ifB.relu_in[21] ? 22'sd0 : ifB.relu_in;
    end

    task automatic loadSmall();
        memS[0] = 22'sd5;
        memS[1] = -22'sd3;
        memS[2] = 22'sd0;
        memS[3] = 22'sd2097151;
    endtask

    task automatic pushSmall(input logic signed [21:0] first);
        expQ.push_back({10'd0, first});
        expQ.push_back({10'd1, 22'sd0});
        expQ.push_back({10'd2, 22'sd0});
        expQ.push_back({10'd3, 22'sd2097151});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({ifS.busy, ifS.done, ifS.relu_enable, ifS.wr_en, ifS.err} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {ifS.busy, ifS.done, ifS.relu_enable, ifS.wr_en, ifS.err});
        end
        compared++;
        if ({ifS.rd_addr, ifS.wr_addr, ifS.wr_data, ifS.relu_in} !== 64'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: rd_addr %0d wr_addr %0d wr_data %0d relu_in %0d expected all 0",
                     ifS.rd_addr, ifS.wr_addr, ifS.wr_data, ifS.relu_in);
        end
        compared++;
        if (ifB.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_big_busy: got %b expected 0", ifB.busy);
        end
    endtask

    task automatic test_basic();
        int cyc = 1;
        int doneCyc = -1;
        int firstWr = -1;
        int nWr = 0;
        wr_t e;
        loadSmall();
        pushSmall(22'sd5);
        ifS.start = 1'b1;
        @(negedge clk);
        ifS.start = 1'b0;
        while (cyc <= 60 && doneCyc < 0) begin
            if (ifS.wr_en) begin
                nWr++;
                if (firstWr < 0) firstWr = cyc;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL basic_extra_write: got write addr %0d expected none", ifS.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifS.wr_addr !== e.addr || ifS.wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL basic_write: got %0d@%0d expected %0d@%0d",
                                 ifS.wr_data, ifS.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifS.done) doneCyc = cyc;
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (firstWr != 5) begin
            mismatched++;
            $display("[TB] FAIL basic_first_wr: got cycle %0d expected 5", firstWr);
        end
        compared++;
        if (doneCyc != 25) begin
            mismatched++;
            $display("[TB] FAIL basic_done_cycle: got %0d expected 25", doneCyc);
        end
        compared++;
        if (nWr != 4 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL basic_write_count: got %0d writes, %0d pending expected 4, 0", nWr, expQ.size());
        end
        compared++;
        if (ifS.err !== 2'b00 || ifS.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_err_idle: got err %b busy %b expected 00 0", ifS.err, ifS.busy);
        end
        expQ.delete();
    endtask

    task automatic test_timeout();
        int cyc = 1;
        int doneCyc = -1;
        int nWr = 0;
        int enRun = 0;
        int enAtDone = -1;
        logic enInFin = 1'b1;
        wr_t e;
        loadSmall();
        stallOn = 1'b1;
        stallAddr = 10'd2;
        expQ.push_back({10'd0, 22'sd5});
        expQ.push_back({10'd1, 22'sd0});
        ifS.start = 1'b1;
        @(negedge clk);
        ifS.start = 1'b0;
        while (cyc <= 60 && doneCyc < 0) begin
            if (ifS.wr_en) begin
                nWr++;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL timeout_extra_write: got write addr %0d expected none", ifS.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifS.wr_addr !== e.addr || ifS.wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL timeout_write: got %0d@%0d expected %0d@%0d",
                                 ifS.wr_data, ifS.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifS.done) begin
                doneCyc = cyc;
                enAtDone = enRun;
                enInFin = ifS.relu_enable;
            end
            if (ifS.relu_enable) enRun++;
            else enRun = 0;
            @(negedge clk);
            cyc++;
        end
        stallOn = 1'b0;
        compared++;
        if (doneCyc != 30) begin
            mismatched++;
            $display("[TB] FAIL timeout_done_cycle: got %0d expected 30", doneCyc);
        end
        compared++;
        if (enAtDone != 15 || enInFin !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_en_cycles: got %0d en cycles, enable %b in FIN expected 15, 0",
                     enAtDone, enInFin);
        end
        compared++;
        if (nWr != 2) begin
            mismatched++;
            $display("[TB] FAIL timeout_write_count: got %0d expected 2", nWr);
        end
        compared++;
        if (ifS.err !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL timeout_err: got %b expected 01", ifS.err);
        end
        expQ.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fault();
        int cyc = 1;
        int doneCyc = -1;
        int nWr = 0;
        wr_t e;
        loadSmall();
        faultOn = 1'b1;
        faultAddr = 10'd0;
        pushSmall(-22'sd1);
        ifS.start = 1'b1;
        @(negedge clk);
        ifS.start = 1'b0;
        compared++;
        if (ifS.err !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL fault_err_cleared: got %b expected 00", ifS.err);
        end
        while (cyc <= 60 && doneCyc < 0) begin
            if (ifS.wr_en) begin
                nWr++;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL fault_extra_write: got write addr %0d expected none", ifS.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifS.wr_addr !== e.addr || ifS.wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL fault_write: got %0d@%0d expected %0d@%0d",
                                 ifS.wr_data, ifS.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifS.done) doneCyc = cyc;
            @(negedge clk);
            cyc++;
        end
        faultOn = 1'b0;
        compared++;
        if (doneCyc != 25 || nWr != 4) begin
            mismatched++;
            $display("[TB] FAIL fault_completion: got done %0d writes %0d expected 25, 4", doneCyc, nWr);
        end
        compared++;
        if (ifS.err !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL fault_err: got %b expected 10", ifS.err);
        end
        expQ.delete();
    endtask

    task automatic test_reset_mid_run();
        int cyc = 1;
        int doneCyc = -1;
        int firstWr = -1;
        int stray = 0;
        wr_t e;
        loadSmall();
        ifS.start = 1'b1;
        @(negedge clk);
        ifS.start = 1'b0;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (ifS.relu_enable !== 1'b1 || ifS.rd_addr !== 10'd1) begin
            mismatched++;
            $display("[TB] FAIL midrst_in_en: got enable %b rd_addr %0d expected 1, 1", ifS.relu_enable, ifS.rd_addr);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ifS.busy, ifS.done, ifS.relu_enable, ifS.wr_en, ifS.err} !== 6'b0 ||
            {ifS.rd_addr, ifS.wr_addr, ifS.wr_data, ifS.relu_in} !== 64'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst_outputs: busy %b en %b err %b rd_addr %0d wr_addr %0d wr_data %0d relu_in %0d expected all 0",
                     ifS.busy, ifS.relu_enable, ifS.err, ifS.rd_addr, ifS.wr_addr, ifS.wr_data, ifS.relu_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ifS.wr_en || ifS.busy) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++;
            $display("[TB] FAIL midrst_no_activity: got %0d active cycles expected 0", stray);
        end
        pushSmall(22'sd5);
        ifS.start = 1'b1;
        @(negedge clk);
        ifS.start = 1'b0;
        cyc = 1;
        while (cyc <= 60 && doneCyc < 0) begin
            if (ifS.wr_en) begin
                if (firstWr < 0) firstWr = cyc;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL midrst_extra_write: got write addr %0d expected none", ifS.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifS.wr_addr !== e.addr || ifS.wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL midrst_write: got %0d@%0d expected %0d@%0d",
                                 ifS.wr_data, ifS.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifS.done) doneCyc = cyc;
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (firstWr != 5 || doneCyc != 25 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL midrst_rerun: got first wr %0d done %0d pending %0d expected 5, 25, 0",
                     firstWr, doneCyc, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        int cyc = 1;
        int doneCnt = 0;
        int secondDone = -1;
        logic busy26 = 1'b1;
        logic busy27 = 1'b0;
        wr_t e;
        loadSmall();
        pushSmall(22'sd5);
        pushSmall(22'sd5);
        ifS.start = 1'b1;
        @(negedge clk);
        while (cyc <= 90 && secondDone < 0) begin
            if (cyc == 26) busy26 = ifS.busy;
            if (cyc == 27) begin
                busy27 = ifS.busy;
                ifS.start = 1'b0;
            end
            if (ifS.wr_en) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_extra_write: got write addr %0d expected none", ifS.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifS.wr_addr !== e.addr || ifS.wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_write: got %0d@%0d expected %0d@%0d",
                                 ifS.wr_data, ifS.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifS.done) begin
                if (cyc <= 26) doneCnt++;
                else secondDone = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        ifS.start = 1'b0;
        compared++;
        if (doneCnt != 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_one_done: got %0d done pulses expected 1", doneCnt);
        end
        compared++;
        if (busy26 !== 1'b0 || busy27 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_restart: got busy %b,%b at cycles 26,27 expected 0,1", busy26, busy27);
        end
        compared++;
        if (secondDone != 51 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_run: got done %0d pending %0d expected 51, 0", secondDone, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_full_map();
        int cyc = 1;
        int doneCyc = -1;
        int busyCnt = 0;
        int nWr = 0;
        int bad = 0;
        logic signed [21:0] x;
        wr_t e;
        for (int i = 0; i < 576; i++) begin
            x = 22'($urandom);
            memB[i] = x;
            expQ.push_back({10'(i), (x[21] ? 22'sd0 : x)});
        end
        ifB.start = 1'b1;
        @(negedge clk);
        ifB.start = 1'b0;
        while (cyc <= 4000 && doneCyc < 0) begin
            if (ifB.busy) busyCnt++;
            if (ifB.wr_en) begin
                nWr++;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL full_extra_write: got write addr %0d expected none", ifB.wr_addr);
                end else begin
                    e = expQ.pop_front();
                    if (ifB.wr_addr !== e.addr || ifB.wr_data !== e.data) begin
                        mismatched++;
                        bad++;
                        if (bad <= 5)
                            $display("[TB] FAIL full_write: got %0d@%0d expected %0d@%0d",
                                     ifB.wr_data, ifB.wr_addr, e.data, e.addr);
                    end
                end
            end
            if (ifB.done) doneCyc = cyc;
            @(negedge clk);
            cyc++;
        end
        compared++;
        if (nWr != 576 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL full_write_count: got %0d pending %0d expected 576, 0", nWr, expQ.size());
        end
        compared++;
        if (busyCnt != 3457 || doneCyc != 3457) begin
            mismatched++;
            $display("[TB] FAIL full_busy_done: got busy %0d done %0d expected 3457, 3457", busyCnt, doneCyc);
        end
        compared++;
        if (ifB.err !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL full_err: got %b expected 00", ifB.err);
        end
        expQ.delete();
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        ifS.start = 1'b0;
        ifB.start = 1'b0;
        for (int i = 0; i < 576; i++) memB[i] = '0;
        loadSmall();
        test_reset();
        test_basic();
        repeat (2) @(negedge clk);
        test_timeout();
        test_fault();
        repeat (2) @(negedge clk);
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_full_map();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
